// File: rtl/aes_stream_engine.sv
// rtl/aes_stream_engine.sv - ECB/CTR streaming front-end (input FIFO, key bank, watchdog) around an iterative AES core
// The AES core is the iterative one-round-per-cycle engine driven by the stream FSM below.

module AES (
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    input  logic         input_valid,
    input  logic         clk,
    input  logic         rst,
    output logic [127:0] cipher_text,
    output logic         output_valid
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box derived arithmetically: GF(2^8) inverse as x^254, then the affine map.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        t  = {sub_byte(rk[23:16]), sub_byte(rk[15:8]), sub_byte(rk[7:0]), sub_byte(rk[31:24])}
             ^ {rc, 24'h000000};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        return {n0, n1, n2, rk[31:0] ^ n2};
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b  [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sub_byte(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[r+4*c] = b[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ rk;
    endfunction

    logic [127:0] st_q, st_d, rk_q, rk_d, ct_q, ct_d;
    logic [127:0] rk_next, st_next;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         run_q, run_d, ov_q, ov_d;

    always_comb begin
        rk_next = key_expand(rk_q, rcon_q);
        st_next = enc_round(st_q, rk_next, round_q == 4'd10);
        st_d    = st_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        run_d   = run_q;
        ct_d    = ct_q;
        ov_d    = 1'b0;
        // A fresh input_valid restarts the core and suppresses any stale completion.
        if (input_valid) begin
            st_d    = plain_text ^ key;
            rk_d    = key;
            rcon_d  = 8'h01;
            round_d = 4'd1;
            run_d   = 1'b1;
        end else if (run_q) begin
            st_d    = st_next;
            rk_d    = rk_next;
            rcon_d  = xtime(rcon_q);
            round_d = round_q + 4'd1;
            if (round_q == 4'd10) begin
                run_d = 1'b0;
                ov_d  = 1'b1;
                ct_d  = st_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            rcon_q  <= 8'h01;
            round_q <= 4'd0;
            run_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            rk_q    <= rk_d;
            ct_q    <= ct_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            run_q   <= run_d;
            ov_q    <= ov_d;
        end
    end

    assign cipher_text  = ct_q;
    assign output_valid = ov_q;

endmodule

module aes_stream_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_SLOTS  = 4,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_key_we,
    input  logic [$clog2(KEY_SLOTS)-1:0] cfg_key_idx,
    input  logic [127:0]                 cfg_key,
    input  logic                         cfg_iv_load,
    input  logic [127:0]                 cfg_iv,
    input  logic                         cfg_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [127:0]                 in_data,
    input  logic [$clog2(KEY_SLOTS)-1:0] in_key_idx,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [127:0]                 out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int KI_W    = $clog2(KEY_SLOTS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int WD_W    = $clog2(TIMEOUT);
    localparam int ENTRY_W = 128 + KI_W + TAG_W;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [127:0]       key_bank_q [KEY_SLOTS];
    logic [127:0]       key_bank_d [KEY_SLOTS];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [127:0]       ctr_q, ctr_d, hold_data_q, hold_data_d, hold_key_q, hold_key_d;
    logic [TAG_W-1:0]   hold_tag_q, hold_tag_d, out_tag_q, out_tag_d;
    logic               hold_mode_q, hold_mode_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               out_valid_q, out_valid_d, err_q, err_d;
    logic [127:0]       out_data_q, out_data_d;

    logic               fifo_full, fifo_empty, push, pop, ctr_inc, core_iv, core_ov;
    logic [ENTRY_W-1:0] head;
    logic [127:0]       core_pt, core_ct;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = in_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign core_pt    = hold_mode_q ? ctr_q : hold_data_q;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        core_iv     = 1'b0;
        ctr_inc     = 1'b0;
        hold_data_d = hold_data_q;
        hold_key_d  = hold_key_q;
        hold_tag_d  = hold_tag_q;
        hold_mode_d = hold_mode_q;
        wdog_d      = wdog_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !out_valid_q) begin
                    pop         = 1'b1;
                    hold_data_d = head[ENTRY_W-1 -: 128];
                    hold_key_d  = key_bank_q[head[TAG_W +: KI_W]];
                    hold_tag_d  = head[TAG_W-1:0];
                    hold_mode_d = cfg_mode;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_iv = 1'b1;
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_ov) begin
                    out_data_d  = hold_mode_q ? (core_ct ^ hold_data_q) : core_ct;
                    out_tag_d   = hold_tag_q;
                    out_valid_d = 1'b1;
                    ctr_inc     = hold_mode_q;
                    state_d     = S_OUT;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        key_bank_d = key_bank_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ctr_d      = ctr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {in_data, in_key_idx, in_tag};
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (cfg_key_we) key_bank_d[cfg_key_idx] = cfg_key;
        // Only the low word counts; a load in the same cycle overrides the increment.
        if (cfg_iv_load)  ctr_d = cfg_iv;
        else if (ctr_inc) ctr_d = {ctr_q[127:32], ctr_q[31:0] + 32'd1};
    end

    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < KEY_SLOTS; i++) key_bank_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ctr_q       <= '0;
            hold_data_q <= '0;
            hold_key_q  <= '0;
            hold_tag_q  <= '0;
            hold_mode_q <= 1'b0;
            wdog_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_bank_q  <= key_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ctr_q       <= ctr_d;
            hold_data_q <= hold_data_d;
            hold_key_q  <= hold_key_d;
            hold_tag_q  <= hold_tag_d;
            hold_mode_q <= hold_mode_d;
            wdog_q      <= wdog_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            err_q       <= err_d;
        end
    end

    AES u_core (
        .plain_text  (core_pt),
        .key         (hold_key_q),
        .input_valid (core_iv),
        .clk         (clk),
        .rst         (rst),
        .cipher_text (core_ct),
        .output_valid(core_ov)
    );

    assign in_ready    = !fifo_full;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_tag     = out_tag_q;
    assign busy        = (state_q != S_IDLE) || !fifo_empty;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_aes_stream_engine.sv
// tb/tb_aes_stream_engine.sv - scoreboard bench for aes_stream_engine against a table-driven AES reference

module tb_aes_stream_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         cfg_key_we, cfg_iv_load, cfg_mode;
    logic [1:0]   cfg_key_idx;
    logic [127:0] cfg_key, cfg_iv;
    logic         in_valid, in_ready, out_valid, out_ready, busy, err_timeout;
    logic [127:0] in_data, out_data;
    logic [1:0]   in_key_idx;
    logic [3:0]   in_tag, out_tag;

    logic         to_in_valid, to_in_ready, to_out_valid, to_busy, to_err;
    logic [127:0] to_in_data, to_out_data;
    logic [3:0]   to_out_tag;

    int checks = 0;
    int errors = 0;
    int ready_mode;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   t;
    } exp_t;
    exp_t sb_q[$];

    logic [127:0] model_key [4];
    logic [127:0] model_ctr;
    logic         model_mode;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [7:0] sbox_tab [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

    aes_stream_engine dut (
        .clk(clk), .rst(rst_n), .cfg_key_we(cfg_key_we), .cfg_key_idx(cfg_key_idx), .cfg_key(cfg_key),
        .cfg_iv_load(cfg_iv_load), .cfg_iv(cfg_iv), .cfg_mode(cfg_mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_key_idx(in_key_idx), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy), .err_timeout(err_timeout)
    );

    aes_stream_engine #(.TIMEOUT(2)) dut_to (
        .clk(clk), .rst(rst_n), .cfg_key_we(1'b0), .cfg_key_idx(2'b00), .cfg_key(128'h0),
        .cfg_iv_load(1'b0), .cfg_iv(128'h0), .cfg_mode(1'b0), .in_valid(to_in_valid),
        .in_ready(to_in_ready), .in_data(to_in_data), .in_key_idx(2'b00), .in_tag(4'h0),
        .out_valid(to_out_valid), .out_ready(1'b1), .out_data(to_out_data), .out_tag(to_out_tag),
        .busy(to_busy), .err_timeout(to_err)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Expected result for a block in acceptance order; CTR consumes one counter value per block.
    function automatic logic [127:0] model_exp(input logic [127:0] d, input logic [1:0] idx);
        logic [127:0] r;
        if (model_mode) begin
            r = ref_aes(model_key[idx], model_ctr) ^ d;
            model_ctr = {model_ctr[127:32], model_ctr[31:0] + 32'd1};
        end else begin
            r = ref_aes(model_key[idx], d);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model_key[i] = '0;
        model_ctr = '0;
    endtask

    task automatic push_blk(input logic [127:0] d, input logic [1:0] idx, input logic [3:0] tag,
                            input bit force_exp, input logic [127:0] fexp);
        int   n;
        exp_t e;
        logic [127:0] m;
        n = 0;
        in_data = d; in_key_idx = idx; in_tag = tag; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL push_wait actual=in_ready_low expected=accept tag=%0d", tag);
        end else begin
            m   = model_exp(d, idx);
            e.d = force_exp ? fexp : m;
            e.t = tag;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic set_key(input logic [1:0] idx, input logic [127:0] k);
        cfg_key_we = 1'b1; cfg_key_idx = idx; cfg_key = k;
        @(posedge clk); #1;
        cfg_key_we = 1'b0;
        model_key[idx] = k;
    endtask

    task automatic load_iv(input logic [127:0] iv);
        cfg_iv_load = 1'b1; cfg_iv = iv;
        @(posedge clk); #1;
        cfg_iv_load = 1'b0;
        model_ctr = iv;
    endtask

    task automatic set_mode(input logic m);
        cfg_mode = m;
        model_mode = m;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || out_valid || sb_q.size() != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (busy || out_valid || sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=pending%0d expected=0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    always begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out actual=tag%0d expected=none", out_tag);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_tag", {124'h0, out_tag}, {124'h0, e.t});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && to_out_valid) begin
            checks++; errors++;
            $display("FAIL timeout_out_valid actual=1 expected=0");
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [127:0] d;
        int n;
        rst_n = 1'b0; ready_mode = 1; out_ready = 1'b1;
        cfg_key_we = 1'b0; cfg_key_idx = '0; cfg_key = '0; cfg_iv_load = 1'b0; cfg_iv = '0;
        cfg_mode = 1'b0; model_mode = 1'b0; in_valid = 1'b0; in_data = '0; in_key_idx = '0; in_tag = '0;
        to_in_valid = 1'b0; to_in_data = '0;
        model_reset();
        #1;
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_out_tag", {124'h0, out_tag}, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_err", {127'h0, err_timeout}, 128'h0);
        chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        set_key(2'd0, FIPS_KEY);
        push_blk(FIPS_PT, 2'd0, 4'd5, 1'b1, FIPS_CT);
        wait_idle();

        set_mode(1'b1);
        load_iv(FIPS_PT);
        push_blk(128'h0, 2'd0, 4'd1, 1'b1, FIPS_CT);
        push_blk(128'h0, 2'd0, 4'd2, 1'b0, 128'h0);
        push_blk(128'h0, 2'd0, 4'd3, 1'b0, 128'h0);
        wait_idle();

        load_iv({{12{8'hA5}}, 32'hFFFFFFFF});
        push_blk({$urandom, $urandom, $urandom, $urandom}, 2'd0, 4'd4, 1'b0, 128'h0);
        push_blk({$urandom, $urandom, $urandom, $urandom}, 2'd0, 4'd6, 1'b0, 128'h0);
        wait_idle();

        set_mode(1'b0);
        set_key(2'd1, {4{32'h1111_2222}});
        push_blk({4{$urandom}}, 2'd1, 4'd7, 1'b0, 128'h0);
        repeat (4) @(posedge clk);
        #1;
        set_key(2'd1, {4{32'h3333_4444}});
        push_blk({4{$urandom}}, 2'd1, 4'd8, 1'b0, 128'h0);
        wait_idle();
        push_blk({4{$urandom}}, 2'd1, 4'd9, 1'b0, 128'h0);
        set_key(2'd1, {4{32'h5555_6666}});
        push_blk({4{$urandom}}, 2'd1, 4'd10, 1'b0, 128'h0);
        wait_idle();

        ready_mode = 0;
        @(posedge clk); #1;
        for (int t = 0; t < 5; t++) push_blk({$urandom, $urandom, $urandom, $urandom}, 2'd0, 4'(t), 1'b0, 128'h0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("bp_out_valid", {127'h0, out_valid}, 128'h1);
        chk("bp_in_ready_full", {127'h0, in_ready}, 128'h0);
        repeat (5) @(negedge clk);
        chk("bp_stall_data", out_data, sb_q[0].d);
        chk("bp_stall_tag", {124'h0, out_tag}, 128'h0);
        @(posedge clk); #1;
        fork
            push_blk({$urandom, $urandom, $urandom, $urandom}, 2'd0, 4'd5, 1'b0, 128'h0);
            begin
                repeat (3) @(posedge clk);
                #1 ready_mode = 1;
            end
        join
        wait_idle();

        for (int rnd = 0; rnd < 3; rnd++) begin
            ready_mode = 1;
            wait_idle();
            set_mode(logic'($urandom_range(0, 1)));
            for (int s = 0; s < 4; s++)
                if ($urandom_range(0, 1) == 1) set_key(2'(s), {$urandom, $urandom, $urandom, $urandom});
            load_iv({$urandom, $urandom, $urandom, ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFD : $urandom});
            ready_mode = 2;
            for (int b = 0; b < 12; b++) begin
                push_blk({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)),
                         4'($urandom_range(0, 15)), 1'b0, 128'h0);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            wait_idle();
        end

        ready_mode = 1;
        set_mode(1'b0);
        push_blk({$urandom, $urandom, $urandom, $urandom}, 2'd0, 4'd3, 1'b0, 128'h0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("midrst_out_data", out_data, 128'h0);
        chk("midrst_out_tag", {124'h0, out_tag}, 128'h0);
        chk("midrst_busy", {127'h0, busy}, 128'h0);
        chk("midrst_in_ready", {127'h0, in_ready}, 128'h1);
        sb_q.delete();
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("postrst_busy", {127'h0, busy}, 128'h0);
        chk("postrst_err", {127'h0, err_timeout}, 128'h0);
        push_blk({$urandom, $urandom, $urandom, $urandom}, 2'd0, 4'd12, 1'b0, 128'h0);
        wait_idle();

        chk("to_err_init", {127'h0, to_err}, 128'h0);
        for (int k = 0; k < 2; k++) begin
            to_in_data = {$urandom, $urandom, $urandom, $urandom};
            to_in_valid = 1'b1;
            @(posedge clk); #1;
            to_in_valid = 1'b0;
            n = 0;
            @(negedge clk);
            while ((to_busy || !to_err) && n < 60) begin
                n++;
                @(negedge clk);
            end
            chk("to_err_set", {127'h0, to_err}, 128'h1);
            chk("to_busy_idle", {127'h0, to_busy}, 128'h0);
            repeat (20) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
